// File: rtl/alu_if.sv
// alu_if: operand/result bundle for the registered integer ALU.
//   in_valid, a, b, op      : request side, driven by the master
//   out_valid, y            : registered result, driven by the slave (ALU)
//   overflow, carry,
//   zero, negative          : status flags that accompany y
// Modports: master (issues operations), slave (the ALU).
interface alu_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic [WIDTH-1:0] y;
  logic             overflow;
  logic             carry;
  logic             zero;
  logic             negative;

  modport master (
    output in_valid, a, b, op,
    input  out_valid, y, overflow, carry, zero, negative
  );

  modport slave (
    input  in_valid, a, b, op,
    output out_valid, y, overflow, carry, zero, negative
  );
endinterface

// File: rtl/alu.sv
// alu: WIDTH-bit integer ALU with one output register stage.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears result, flags and out_valid
//   bus   : alu_if.slave carrying in_valid/a/b/op in and out_valid/y/flags out
// Opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
// Shift amount is b[SHW-1:0]; y and flags hold when in_valid is low.
module alu #(
  parameter int WIDTH = 8
) (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  localparam int SHW = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_SLL = 3'b101,
    OP_SRL = 3'b110,
    OP_SRA = 3'b111
  } op_e;

  // Shift amounts beyond the operand width only exist for non-power-of-two WIDTH.
  function automatic logic sh_big(input logic [SHW-1:0] s);
    return 32'(s) >= 32'(WIDTH);
  endfunction

  // Returns {carry, y}; the extra MSB catches the last bit shifted out.
  function automatic logic [WIDTH:0] shift_left(input logic [WIDTH-1:0] v,
                                                input logic [SHW-1:0]   s);
    if (sh_big(s)) return '0;
    return {1'b0, v} << s;
  endfunction

  // Returns {y, carry}; the extra LSB catches the last bit shifted out.
  function automatic logic [WIDTH:0] shift_right(input logic [WIDTH-1:0] v,
                                                 input logic [SHW-1:0]   s,
                                                 input logic             arith);
    logic signed [WIDTH:0] t;
    if (sh_big(s))
      return arith ? {(WIDTH+1){v[WIDTH-1]}} : '0;
    t = {v, 1'b0};
    if (arith) return t >>> s;
    return {v, 1'b0} >> s;
  endfunction

  logic signed [WIDTH-1:0] a_s, b_s, sum_s, dif_s;
  logic        [WIDTH:0]   sum_ext, dif_ext, sh_res;
  logic        [SHW-1:0]   sh;
  logic        [WIDTH-1:0] y_nxt;
  logic                    ovf_nxt, cry_nxt;

  logic        [WIDTH-1:0] y_p1;
  logic                    ovf_p1, cry_p1, zero_p1, neg_p1, vld_p1;

  // Stage 0: combinational result and flags from the current a/b/op
  always_comb begin
    a_s     = signed'(bus.a);
    b_s     = signed'(bus.b);
    sum_s   = a_s + b_s;
    dif_s   = a_s - b_s;
    sum_ext = {1'b0, bus.a} + {1'b0, bus.b};
    dif_ext = {1'b0, bus.a} - {1'b0, bus.b};
    sh      = bus.b[SHW-1:0];
    sh_res  = '0;
    y_nxt   = '0;
    ovf_nxt = 1'b0;
    cry_nxt = 1'b0;
    case (op_e'(bus.op))
      OP_ADD: begin
        y_nxt   = sum_ext[WIDTH-1:0];
        cry_nxt = sum_ext[WIDTH];
        ovf_nxt = ((a_s < 0) == (b_s < 0)) && ((sum_s < 0) != (a_s < 0));
      end
      OP_SUB: begin
        y_nxt   = dif_ext[WIDTH-1:0];
        cry_nxt = dif_ext[WIDTH];  // wraps high exactly when a < b
        ovf_nxt = ((a_s < 0) != (b_s < 0)) && ((dif_s < 0) != (a_s < 0));
      end
      OP_AND: y_nxt = bus.a & bus.b;
      OP_OR:  y_nxt = bus.a | bus.b;
      OP_XOR: y_nxt = bus.a ^ bus.b;
      OP_SLL: begin
        sh_res  = shift_left(bus.a, sh);
        y_nxt   = sh_res[WIDTH-1:0];
        cry_nxt = sh_res[WIDTH];
      end
      OP_SRL: begin
        sh_res  = shift_right(bus.a, sh, 1'b0);
        y_nxt   = sh_res[WIDTH:1];
        cry_nxt = sh_res[0];
      end
      OP_SRA: begin
        sh_res  = shift_right(bus.a, sh, 1'b1);
        y_nxt   = sh_res[WIDTH:1];
        cry_nxt = sh_res[0];
      end
      default: begin
        y_nxt   = '0;
        cry_nxt = 1'b0;
      end
    endcase
  end

  // Stage 1: output registers, loaded only for qualified operations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      y_p1    <= '0;
      ovf_p1  <= 1'b0;
      cry_p1  <= 1'b0;
      zero_p1 <= 1'b0;
      neg_p1  <= 1'b0;
    end else begin
      vld_p1 <= bus.in_valid;
      if (bus.in_valid) begin
        y_p1    <= y_nxt;
        ovf_p1  <= ovf_nxt;
        cry_p1  <= cry_nxt;
        zero_p1 <= (y_nxt == '0);
        neg_p1  <= y_nxt[WIDTH-1];
      end
    end
  end

  assign bus.out_valid = vld_p1;
  assign bus.y         = y_p1;
  assign bus.overflow  = ovf_p1;
  assign bus.carry     = cry_p1;
  assign bus.zero      = zero_p1;
  assign bus.negative  = neg_p1;

endmodule

// File: tb/tb_alu.sv
// tb_alu: scoreboard bench for the 8-bit alu. Stimulus is driven on the
// falling edge; the expected result is pushed at issue and popped one cycle
// later when the registered output is sampled on the next falling edge.
module tb_alu;
  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] y;
    logic         ov;
    logic         c;
    logic         z;
    logic         n;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  exp_t sbq[$];

  alu_if #(.WIDTH(W)) bus ();
  alu #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  // Reference model: integer arithmetic and bit-at-a-time shifting.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op);
    exp_t e;
    int ua, ub, sa, sb, r, rs, sh;
    logic [W-1:0] y;
    logic c, ov;
    ua = int'(a); ub = int'(b);
    sa = int'($signed(a)); sb = int'($signed(b));
    sh = int'(b[2:0]);
    y = a; c = 1'b0; ov = 1'b0;
    case (op)
      3'd0: begin r = ua + ub; y = r[W-1:0]; c = (r > 255);
                  rs = sa + sb; ov = (rs > 127) || (rs < -128); end
      3'd1: begin r = ua - ub; y = r[W-1:0]; c = (ua < ub);
                  rs = sa - sb; ov = (rs > 127) || (rs < -128); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd5: for (int k = 0; k < sh; k++) begin c = y[W-1]; y = {y[W-2:0], 1'b0}; end
      3'd6: for (int k = 0; k < sh; k++) begin c = y[0]; y = {1'b0, y[W-1:1]}; end
      default: for (int k = 0; k < sh; k++) begin c = y[0]; y = {y[W-1], y[W-1:1]}; end
    endcase
    e.y = y; e.ov = ov; e.c = c; e.z = (y == '0); e.n = y[W-1];
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    bus.in_valid = 1'b1;
    bus.a = a; bus.b = b; bus.op = op;
    sbq.push_back(model(a, b, op));
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.y, bus.overflow, bus.carry, bus.zero, bus.negative} !== '0)
      begin errors++; $display("FAIL reset_state: got vld=%b y=%h ov=%b c=%b z=%b n=%b, expected all 0",
        bus.out_valid, bus.y, bus.overflow, bus.carry, bus.zero, bus.negative); end
    rst_n = 1'b1;
    issue(8'd1, 8'd2, 3'b000);
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.y !== 8'd3 || bus.carry !== 1'b0 || bus.overflow !== 1'b0 ||
        bus.zero !== 1'b0 || bus.negative !== 1'b0 || e.y !== bus.y)
      begin errors++; $display("FAIL first_add: got vld=%b y=%h ov=%b c=%b z=%b n=%b, expected vld=1 y=03 flags 0",
        bus.out_valid, bus.y, bus.overflow, bus.carry, bus.zero, bus.negative); end
    // Asynchronous assertion while out_valid is high, away from any clock edge.
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.out_valid, bus.y, bus.overflow, bus.carry, bus.zero, bus.negative} !== '0)
      begin errors++; $display("FAIL async_reset: got vld=%b y=%h ov=%b c=%b z=%b n=%b, expected all 0",
        bus.out_valid, bus.y, bus.overflow, bus.carry, bus.zero, bus.negative); end
    bus.in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.out_valid, bus.y} !== '0)
      begin errors++; $display("FAIL reset_hold: got vld=%b y=%h, expected vld=0 y=00", bus.out_valid, bus.y); end
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    logic [W-1:0] ta [8] = '{8'h01, 8'h7F, 8'hFF, 8'h00, 8'h80, 8'h05, 8'h80, 8'hC0};
    logic [W-1:0] tb [8] = '{8'h02, 8'h01, 8'h01, 8'h01, 8'h01, 8'h05, 8'h80, 8'h40};
    logic [2:0]   to [8] = '{3'd0,  3'd0,  3'd0,  3'd1,  3'd1,  3'd1,  3'd0,  3'd1};
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      issue(ta[i], tb[i], to[i]);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.y, bus.overflow, bus.carry, bus.zero, bus.negative} !== e)
        begin errors++; $display("FAIL arith%0d: got vld=%b y=%h ov=%b c=%b z=%b n=%b, expected vld=1 y=%h ov=%b c=%b z=%b n=%b",
          i, bus.out_valid, bus.y, bus.overflow, bus.carry, bus.zero, bus.negative, e.y, e.ov, e.c, e.z, e.n); end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_logic_shift();
    logic [W-1:0] ta [14] = '{8'hF0, 8'hF0, 8'hF0, 8'h81, 8'h81, 8'h80, 8'hA5, 8'hA5,
                              8'hA5, 8'h7F, 8'h01, 8'h81, 8'hC3, 8'h3C};
    logic [W-1:0] tb [14] = '{8'h3C, 8'h3C, 8'h3C, 8'h01, 8'h01, 8'h03, 8'h00, 8'h00,
                              8'h00, 8'h07, 8'h07, 8'hF9, 8'h04, 8'h06};
    logic [2:0]   to [14] = '{3'd2,  3'd3,  3'd4,  3'd5,  3'd6,  3'd7,  3'd5,  3'd6,
                              3'd7,  3'd7,  3'd5,  3'd6,  3'd7,  3'd5};
    exp_t e;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      issue(ta[i], tb[i], to[i]);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (bus.out_valid !== 1'b1 || {bus.y, bus.overflow, bus.carry, bus.zero, bus.negative} !== e)
        begin errors++; $display("FAIL logic_shift%0d: got vld=%b y=%h ov=%b c=%b z=%b n=%b, expected vld=1 y=%h ov=%b c=%b z=%b n=%b",
          i, bus.out_valid, bus.y, bus.overflow, bus.carry, bus.zero, bus.negative, e.y, e.ov, e.c, e.z, e.n); end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i <= 40; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = sbq.pop_front();
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.y, bus.overflow, bus.carry, bus.zero, bus.negative} !== e)
          begin errors++; $display("FAIL b2b%0d: got vld=%b y=%h ov=%b c=%b z=%b n=%b, expected vld=1 y=%h ov=%b c=%b z=%b n=%b",
            i, bus.out_valid, bus.y, bus.overflow, bus.carry, bus.zero, bus.negative, e.y, e.ov, e.c, e.z, e.n); end
      end
      if (i < 40) issue(W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
      else bus.in_valid = 1'b0;
    end
  endtask

  task automatic test_hold();
    exp_t e;
    @(negedge clk);
    issue(8'h7F, 8'h01, 3'd0);
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (bus.out_valid !== 1'b1 || {bus.y, bus.overflow, bus.carry, bus.zero, bus.negative} !== e)
      begin errors++; $display("FAIL hold_load: got vld=%b y=%h, expected vld=1 y=%h", bus.out_valid, bus.y, e.y); end
    bus.in_valid = 1'b0;
    bus.a = 8'h00; bus.b = 8'h00; bus.op = 3'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b0 || {bus.y, bus.overflow, bus.carry, bus.zero, bus.negative} !== e)
        begin errors++; $display("FAIL hold%0d: got vld=%b y=%h ov=%b c=%b z=%b n=%b, expected vld=0 y=%h ov=%b c=%b z=%b n=%b",
          i, bus.out_valid, bus.y, bus.overflow, bus.carry, bus.zero, bus.negative, e.y, e.ov, e.c, e.z, e.n); end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic_shift();
    test_back_to_back();
    test_hold();
    checks++;
    if (sbq.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d pending results, expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- Parameterizable-width integer ALU with registered outputs.
- Performs add, subtract, bitwise logic and shifts on two WIDTH-bit operands selected by a 3-bit opcode.
- Produces a result plus four status flags (overflow, carry, zero, negative) for the datapath/flag register that consumes them.
- One pipeline stage: inputs sampled on a rising clock edge, results visible one cycle later.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range >= 2).

Ports:
- Clock and reset follow the codebase's naming (clk, rst_n). There is one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  qualifies a, b, op for this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; low SHW bits give the shift amount, where SHW = max(1, $clog2(WIDTH)).
- op  input  3  operation select.
- out_valid  output  1  y and flags hold a fresh result.
- y  output  WIDTH  result.
- overflow  output  1  signed overflow.
- carry  output  1  carry / borrow / shifted-out bit.
- zero  output  1  y == 0.
- negative  output  1  y[WIDTH-1].

Behaviour:
- Reset (asynchronous, rst_n low): y=0, overflow=0, carry=0, zero=0, negative=0, out_valid=0. These values hold while rst_n is low. Release is synchronous to the next clk edge.
- Latency: 1 cycle. On a rising edge with in_valid=1, registers load the result computed from the current a/b/op, and out_valid=1 on the following cycle.
- On an edge with in_valid=0: out_valid goes to 0; y and all flags hold their previous values.
- No backpressure. A new operation may be issued every cycle.
- Opcodes:
  - 000 ADD: y = a + b mod 2^WIDTH; carry = unsigned carry-out.
  - 001 SUB: y = a - b mod 2^WIDTH; carry = borrow, 1 iff a < b unsigned.
  - 010 AND, 011 OR, 100 XOR: bitwise operations; carry=0, overflow=0.
  - 101 SLL: y = a << sh; carry = last bit shifted out (a[WIDTH-sh]); 0 when sh=0.
  - 110 SRL: y = a >> sh, zero fill; carry = a[sh-1]; 0 when sh=0.
  - 111 SRA: y = a >>> sh, sign fill; carry = a[sh-1]; 0 when sh=0.
- Shift amount sh = b[SHW-1:0]. If sh >= WIDTH (possible for non-power-of-two WIDTH):
  - SLL/SRL: y=0, carry=0.
  - SRA: y = all copies of a[WIDTH-1], carry = a[WIDTH-1].
- Overflow:
  - ADD: 1 iff a and b have the same sign and y's sign differs.
  - SUB: 1 iff a and b have different signs and y's sign differs from a.
  - All other ops: 0.
- zero = (y == 0); negative = y[WIDTH-1]. Both are computed for every op from the registered result.
- All next-state logic is combinational from a, b, op. No internal state other than the output registers.
- X-free: every op value is decoded; there are no don't-care result paths.

Test Plan (WIDTH=8):
- Reset: assert rst_n=0 mid-cycle with out_valid=1 -> all outputs clear immediately, without waiting for clk. Release rst_n, drive in_valid=1, a=1, b=2, op=000 -> next cycle y=3, carry=0, overflow=0, zero=0, negative=0, out_valid=1.
- ADD boundaries:
  - a=0x7F, b=0x01, op=000 -> y=0x80, overflow=1, negative=1, carry=0.
  - a=0xFF, b=0x01 -> y=0x00, carry=1, zero=1, overflow=0.
- SUB:
  - a=0x00, b=0x01, op=001 -> y=0xFF, carry=1, negative=1, overflow=0.
  - a=0x80, b=0x01 -> y=0x7F, overflow=1.
  - a=5, b=5 -> y=0, zero=1, carry=0.
- Logic: a=0xF0, b=0x3C -> AND y=0x30; OR y=0xFC, negative=1; XOR y=0xCC. For all three, carry=0 and overflow=0.
- Shifts:
  - SLL a=0x81, b=1 -> y=0x02, carry=1.
  - SRL a=0x81, b=1 -> y=0x40, carry=1.
  - SRA a=0x80, b=3 -> y=0xF0, carry=0.
  - Any shift with b=0 -> y=a, carry=0.
- Valid/hold: back-to-back ops on consecutive cycles produce results on consecutive cycles. Dropping in_valid -> out_valid=0 while y and flags keep the last result.
